// File: rtl/matrix_alu_responder.sv
// Responder end of the engine-to-ALU link: 2x2 matrix
// register file with load/store, elementwise math and matrix multiply.
// Ports: clk, reset (async, high), n_alu_enable, op_select, alu_address,
//        data_in, data_out, data_valid, busy, done, cmd_err.
module matrix_alu_responder #(
  parameter int DATA_W     = 16,
  parameter int NREG       = 8,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  n_alu_enable,
  input  logic [2:0]            op_select,
  input  logic [2:0]            alu_address,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [4*DATA_W-1:0]   data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int W  = DATA_W;
  localparam int MW = 4 * DATA_W;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SCAL  = 3'b100;
  localparam logic [2:0] OP_MATR  = 3'b101;
  localparam logic [2:0] OP_TRANS = 3'b110;
  localparam logic [2:0] OP_STORE = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t        state, state_nx;
  logic          prev_en;
  logic          accept;
  logic [1:0]    k;
  logic          k_last;
  logic [MW-1:0] regs [NREG];
  logic [MW-1:0] sh_a, sh_b;
  logic [MW-1:0] sres;
  logic [W-1:0]  mres;
  logic [1:0]    ai0, ai1, b0j, b1j;

  function automatic logic [W-1:0] el(
    input logic [MW-1:0] m,
    input logic [1:0]    idx
  );
    return m[idx*W +: W];
  endfunction

  // Falling-edge detect: a held-low strobe is one command.
  assign accept = prev_en & ~n_alu_enable;
  assign busy   = (state == MUL);
  assign k_last = (k == 2'(MUL_CYCLES - 1));

  assign data_valid = ~n_alu_enable & (op_select == OP_STORE);
  assign data_out   = data_valid ? regs[alu_address] : '0;

  always_comb begin
    sres = '0;
    for (int e = 0; e < 4; e++) begin
      unique case (op_select)
        OP_ADD:  sres[e*W +: W] = el(regs[0], 2'(e)) + el(regs[1], 2'(e));
        OP_SUB:  sres[e*W +: W] = el(regs[0], 2'(e)) - el(regs[1], 2'(e));
        OP_SCAL: sres[e*W +: W] = el(regs[0], 2'(e)) * el(regs[1], 2'd0);
        default: sres[e*W +: W] = '0;
      endcase
    end
    if (op_select == OP_TRANS)
      sres = {el(regs[0], 2'd3), el(regs[0], 2'd1),
              el(regs[0], 2'd2), el(regs[0], 2'd0)};
  end

  // k = {i, j}: row i of A against column j of B.
  assign ai0  = {k[1], 1'b0};
  assign ai1  = {k[1], 1'b1};
  assign b0j  = {1'b0, k[0]};
  assign b1j  = {1'b1, k[0]};
  assign mres = el(sh_a, ai0) * el(sh_b, b0j)
              + el(sh_a, ai1) * el(sh_b, b1j);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && op_select == OP_MATR) state_nx = MUL;
      MUL:  if (k_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_en <= 1'b1;
      k       <= '0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
      sh_a    <= '0;
      sh_b    <= '0;
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      prev_en <= n_alu_enable;
      done    <= 1'b0;
      if (busy) begin
        regs[2][k*W +: W] <= mres;
        k <= k + 2'd1;
        if (k_last) done <= 1'b1;
      end
      if (accept) begin
        if (busy) begin
          if (op_select != OP_NOP && op_select != OP_STORE)
            cmd_err <= 1'b1;
        end else begin
          unique case (op_select)
            OP_LOAD: regs[alu_address] <= data_in;
            OP_ADD, OP_SUB, OP_SCAL, OP_TRANS: begin
              regs[2] <= sres;
              done    <= 1'b1;
            end
            OP_MATR: begin
              sh_a <= regs[0];
              sh_b <= regs[1];
              k    <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_alu_responder.sv
// Self-checking bench for matrix_alu_responder.
// Table of single-cycle ops plus hand sequences for multiply/collision/reset.
module tb_matrix_alu_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        n_alu_enable;
  logic [2:0]  op_select;
  logic [2:0]  alu_address;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        cmd_err;

  matrix_alu_responder dut (
    .clk          (clk),
    .reset        (reset),
    .n_alu_enable (n_alu_enable),
    .op_select    (op_select),
    .alu_address  (alu_address),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .done         (done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb [$];

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tv [6];

  function automatic logic [63:0] pk(
    input logic [15:0] e00, e01, e10, e11
  );
    return {e11, e10, e01, e00};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] addr,
                       input logic [63:0] din, output logic dn);
    @(negedge clk);
    n_alu_enable = 1'b0;
    op_select    = op;
    alu_address  = addr;
    data_in      = din;
    @(negedge clk);
    dn = done;
    n_alu_enable = 1'b1;
    op_select    = 3'b000;
  endtask

  task automatic load(input logic [2:0] addr, input logic [63:0] din);
    logic dn;
    issue(3'b001, addr, din, dn);
  endtask

  task automatic store(input logic [2:0] addr, output logic [63:0] d,
                       output logic v);
    @(negedge clk);
    n_alu_enable = 1'b0;
    op_select    = 3'b111;
    alu_address  = addr;
    #1;
    d = data_out;
    v = data_valid;
    @(negedge clk);
    n_alu_enable = 1'b1;
    op_select    = 3'b000;
  endtask

  task automatic check_r2(input string nm);
    logic [63:0] d, e;
    logic v;
    store(3'd2, d, v);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk(nm, d, e);
    end
  endtask

  // Starts a multiply; optionally injects one command at the 2nd MUL edge.
  task automatic run_mul(input bit intrude, input logic [2:0] iop,
                         input logic [2:0] iaddr, input logic [63:0] idin,
                         output int bc, output int dc);
    @(negedge clk);
    n_alu_enable = 1'b0;
    op_select    = 3'b101;
    bc = 0;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_alu_enable = 1'b1;
        op_select    = 3'b000;
      end
      if (i == 1 && intrude) begin
        n_alu_enable = 1'b0;
        op_select    = iop;
        alu_address  = iaddr;
        data_in      = idin;
      end
      if (i == 2 && intrude) begin
        n_alu_enable = 1'b1;
        op_select    = 3'b000;
      end
      bc += int'(busy);
      dc += int'(done);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic        v;
    logic        dn;
    int          bc, dc;
    logic [63:0] mul_exp;

    tv[0] = '{"add_wrap",  3'b010, pk(1, 2, 3, 16'hFFFF), pk(1, 1, 1, 1),
              pk(2, 3, 4, 0)};
    tv[1] = '{"sub",       3'b011, pk(1, 2, 3, 16'hFFFF), pk(1, 1, 1, 1),
              pk(0, 1, 2, 16'hFFFE)};
    tv[2] = '{"scal",      3'b100, pk(1, 2, 3, 4), pk(3, 9, 9, 9),
              pk(3, 6, 9, 12)};
    tv[3] = '{"scal_wrap", 3'b100, pk(16'h8000, 16'hFFFF, 2, 0),
              pk(2, 0, 0, 0), pk(0, 16'hFFFE, 4, 0)};
    tv[4] = '{"transpose", 3'b110, pk(1, 2, 3, 4), pk(7, 7, 7, 7),
              pk(1, 3, 2, 4)};
    tv[5] = '{"sub_wrap",  3'b011, pk(0, 0, 0, 0), pk(1, 2, 3, 4),
              pk(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC)};
    mul_exp = pk(19, 22, 43, 50);

    reset        = 1'b1;
    n_alu_enable = 1'b1;
    op_select    = 3'b000;
    alu_address  = 3'b000;
    data_in      = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err",  64'(cmd_err), 64'd0);
    reset = 1'b0;
    store(3'd3, d, v);
    chk("rst_r3", d, 64'd0);

    // LOAD then STORE round trip
    issue(3'b001, 3'd3, 64'h0004_0003_0002_0001, dn);
    chk("load_nodone", 64'(dn), 64'd0);
    store(3'd3, d, v);
    chk("store_data", d, 64'h0004_0003_0002_0001);
    chk("store_valid", 64'(v), 64'd1);
    #1;
    chk("store_idle_data", data_out, 64'd0);
    chk("store_idle_valid", 64'(data_valid), 64'd0);

    // Single-cycle ops from the table
    foreach (tv[i]) begin
      load(3'd0, tv[i].a);
      load(3'd1, tv[i].b);
      issue(tv[i].op, 3'd5, '0, dn);
      sb.push_back(tv[i].exp);
      chk({tv[i].name, "_done"}, 64'(dn), 64'd1);
      check_r2(tv[i].name);
    end

    // NOP: no done, R2 untouched
    issue(3'b000, 3'd2, 64'hDEAD, dn);
    chk("nop_done", 64'(dn), 64'd0);
    sb.push_back(tv[5].exp);
    check_r2("nop_r2");

    // Matrix multiply
    load(3'd0, pk(1, 2, 3, 4));
    load(3'd1, pk(5, 6, 7, 8));
    run_mul(1'b0, 3'b000, 3'd0, '0, bc, dc);
    sb.push_back(mul_exp);
    chk("mul_busy_cycles", 64'(bc), 64'd4);
    chk("mul_done_pulses", 64'(dc), 64'd1);
    chk("mul_no_err", 64'(cmd_err), 64'd0);
    check_r2("mul_result");

    // Collision: ADD during multiply
    run_mul(1'b1, 3'b010, 3'd0, '0, bc, dc);
    sb.push_back(mul_exp);
    chk("coll_add_err", 64'(cmd_err), 64'd1);
    chk("coll_add_done", 64'(dc), 64'd1);
    check_r2("coll_add_r2");

    // Collision: LOAD R0 during multiply
    run_mul(1'b1, 3'b001, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD, bc, dc);
    sb.push_back(mul_exp);
    check_r2("coll_load_r2");
    store(3'd0, d, v);
    chk("coll_r0_kept", d, pk(1, 2, 3, 4));
    chk("coll_err_sticky", 64'(cmd_err), 64'd1);

    // Held enable: one ADD, one done
    load(3'd1, pk(1, 1, 1, 1));
    @(negedge clk);
    n_alu_enable = 1'b0;
    op_select    = 3'b010;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_alu_enable = 1'b1;
        op_select    = 3'b000;
      end
      dc += int'(done);
    end
    sb.push_back(pk(2, 3, 4, 5));
    chk("held_done_pulses", 64'(dc), 64'd1);
    check_r2("held_r2");
    chk("held_err_sticky", 64'(cmd_err), 64'd1);

    // Reset in the middle of a multiply
    @(negedge clk);
    n_alu_enable = 1'b0;
    op_select    = 3'b101;
    @(negedge clk);
    n_alu_enable = 1'b1;
    op_select    = 3'b000;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_err",  64'(cmd_err), 64'd0);
    store(3'd0, d, v);
    chk("mrst_r0", d, 64'd0);
    store(3'd1, d, v);
    chk("mrst_r1", d, 64'd0);
    store(3'd2, d, v);
    chk("mrst_r2", d, 64'd0);
    store(3'd3, d, v);
    chk("mrst_r3", d, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_r2_idle", 64'(busy), 64'd0);
    store(3'd2, d, v);
    chk("post_rst_r2", d, 64'd0);
    load(3'd6, 64'h1234_5678_9ABC_DEF0);
    store(3'd6, d, v);
    chk("post_rst_roundtrip", d, 64'h1234_5678_9ABC_DEF0);
    chk("post_rst_valid", 64'(v), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
